rtc_bus_driver: RTL and testbench

Parallel-bus master between the PicoBlaze RTC controller and the external multiplexed address/data RTC chip. It decodes the controller's output-port writes (port_id/out_port/write_strobe) into RTC register write and read cycles with programmable phase timing. It returns completion flags and read data on the controller's input ports donew_port, doner_port and datao_rtc_port.

---
 rtl/rtc_bus_pkg.sv | 32 +++
 rtl/rtc_bus_driver_phase_timer.sv | 28 ++
 rtl/rtc_bus_driver.sv | 185 ++++++++++++++++++
 tb/tb_rtc_bus_driver.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC parallel-bus driver: FSM encoding, default
// controller port ids and the bit layout of the done/busy status bytes.
package rtc_bus_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_A_SETUP,
    ST_A_STROBE,
    ST_A_HOLD,
    ST_GAP,
    ST_D_SETUP,
    ST_D_STROBE,
    ST_D_HOLD,
    ST_DONE
  } state_t;

  localparam logic [7:0] PORT_ADDR_DEFAULT  = 8'h01;
  localparam logic [7:0] PORT_WDATA_DEFAULT = 8'h02;
  localparam logic [7:0] PORT_RCMD_DEFAULT  = 8'h03;

  localparam int DONE_BIT = 0;
  localparam int BUSY_BIT = 1;

  function automatic logic [7:0] status_byte(input logic done, input logic busy);
    logic [7:0] s;
    s           = '0;
    s[DONE_BIT] = done;
    s[BUSY_BIT] = busy;
    return s;
  endfunction

endpackage

// File: rtl/rtc_bus_driver_phase_timer.sv
// Phase down-counter: a load pulse starts a T_PHASE-cycle interval and
// expired is high during the last cycle of it (and whenever idle).
module rtc_phase_timer #(
  parameter int T_PHASE = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  output logic expired
);

  localparam int CW = $clog2(T_PHASE + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(T_PHASE - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/rtc_bus_driver.sv
// Multiplexed address/data RTC bus master driven by PicoBlaze port writes.
// Optional feature: define RTC_CMD_QUEUE_EN for a one-deep pending command slot.
module rtc_bus_driver
  import rtc_bus_pkg::*;
#(
  parameter logic [7:0] PORT_ADDR  = PORT_ADDR_DEFAULT,
  parameter logic [7:0] PORT_WDATA = PORT_WDATA_DEFAULT,
  parameter logic [7:0] PORT_RCMD  = PORT_RCMD_DEFAULT,
  parameter int         T_PHASE    = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] port_id,
  input  logic [7:0] out_port,
  input  logic       write_strobe,
  output logic [7:0] donew_port,
  output logic [7:0] doner_port,
  output logic [7:0] datao_rtc_port,
  output logic       rtc_cs_n,
  output logic       rtc_wr_n,
  output logic       rtc_rd_n,
  output logic       rtc_ad,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in
);

  state_t     state, state_next;
  logic       op_read, start, start_read, timer_load, expired, busy;
  logic       done_w, done_r, cmd_hit, cmd_read, next_read;
  logic [7:0] start_data, addr_q, data_q;
  logic       pend_vld, pend_read;
  logic [7:0] pend_data;

  assign cmd_hit  = write_strobe && ((port_id == PORT_WDATA) || (port_id == PORT_RCMD));
  assign cmd_read = (port_id == PORT_RCMD);
  assign busy     = (state != ST_IDLE) || pend_vld;

  rtc_phase_timer #(.T_PHASE(T_PHASE)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .load    (timer_load),
    .expired (expired)
  );

`ifdef RTC_CMD_QUEUE_EN
  // The slot fills only while a cycle is running and drains on the IDLE
  // cycle right after DONE, which is also when its command launches.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_vld  <= 1'b0;
      pend_read <= 1'b0;
      pend_data <= '0;
    end else if (state == ST_IDLE && pend_vld) begin
      pend_vld <= 1'b0;
    end else if (cmd_hit && state != ST_IDLE && !pend_vld) begin
      pend_vld  <= 1'b1;
      pend_read <= cmd_read;
      pend_data <= out_port;
    end
  end
`else
  assign pend_vld  = 1'b0;
  assign pend_read = 1'b0;
  assign pend_data = '0;
`endif

  always_comb begin
    start      = 1'b0;
    start_read = op_read;
    start_data = data_q;
    if (state == ST_IDLE) begin
      if (pend_vld) begin
        start      = 1'b1;
        start_read = pend_read;
        start_data = pend_read ? data_q : pend_data;
      end else if (cmd_hit) begin
        start      = 1'b1;
        start_read = cmd_read;
        start_data = cmd_read ? data_q : out_port;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    timer_load = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_A_SETUP;
          timer_load = 1'b1;
        end
      end
      ST_A_SETUP:  if (expired) begin state_next = ST_A_STROBE; timer_load = 1'b1; end
      ST_A_STROBE: if (expired) begin state_next = ST_A_HOLD;   timer_load = 1'b1; end
      ST_A_HOLD:   if (expired) begin state_next = ST_GAP;      timer_load = 1'b1; end
      ST_GAP:      if (expired) begin state_next = ST_D_SETUP;  timer_load = 1'b1; end
      ST_D_SETUP:  if (expired) begin state_next = ST_D_STROBE; timer_load = 1'b1; end
      ST_D_STROBE: if (expired) begin state_next = ST_D_HOLD;   timer_load = 1'b1; end
      ST_D_HOLD:   if (expired) state_next = ST_DONE;
      ST_DONE:     state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q         <= '0;
      data_q         <= '0;
      op_read        <= 1'b0;
      done_w         <= 1'b0;
      done_r         <= 1'b0;
      datao_rtc_port <= '0;
    end else begin
      if (write_strobe && port_id == PORT_ADDR && !busy) addr_q <= out_port;
      if (start) begin
        data_q  <= start_data;
        op_read <= start_read;
        done_w  <= 1'b0;
        done_r  <= 1'b0;
      end
      if (state == ST_DONE) begin
        if (op_read) done_r <= 1'b1;
        else         done_w <= 1'b1;
      end
      if (state == ST_D_STROBE && expired && op_read) datao_rtc_port <= ad_in;
    end
  end

  // Bus pins are registered from the next state so they change cleanly on the
  // clock edge that enters each phase; ad_out holds through GAP/DONE/IDLE.
  assign next_read = start ? start_read : op_read;

  always_ff @(posedge clock) begin
    if (reset) begin
      rtc_cs_n <= 1'b1;
      rtc_wr_n <= 1'b1;
      rtc_rd_n <= 1'b1;
      rtc_ad   <= 1'b0;
      ad_oe    <= 1'b0;
      ad_out   <= '0;
    end else begin
      rtc_cs_n <= 1'b1;
      rtc_wr_n <= 1'b1;
      rtc_rd_n <= 1'b1;
      ad_oe    <= 1'b0;
      case (state_next)
        ST_A_SETUP, ST_A_STROBE, ST_A_HOLD: begin
          rtc_cs_n <= 1'b0;
          rtc_ad   <= 1'b0;
          ad_oe    <= 1'b1;
          ad_out   <= addr_q;
          rtc_wr_n <= (state_next != ST_A_STROBE);
        end
        ST_GAP: rtc_cs_n <= 1'b0;
        ST_D_SETUP, ST_D_STROBE, ST_D_HOLD: begin
          rtc_cs_n <= 1'b0;
          rtc_ad   <= 1'b1;
          if (next_read) begin
            rtc_rd_n <= (state_next != ST_D_STROBE);
          end else begin
            ad_oe    <= 1'b1;
            ad_out   <= data_q;
            rtc_wr_n <= (state_next != ST_D_STROBE);
          end
        end
        ST_IDLE: rtc_ad <= 1'b0;
        default: ;
      endcase
    end
  end

  assign donew_port = status_byte(done_w, busy);
  assign doner_port = status_byte(done_r, busy);

endmodule

// File: tb/tb_rtc_bus_driver.sv
// Scoreboard bench for rtc_bus_driver: a transaction-level model predicts each
// accepted bus cycle and a bus monitor checks it when its done flag rises.
module tb_rtc_bus_driver;

  localparam int T  = 10;
  localparam int TX = 7 * T + 1;
`ifdef RTC_CMD_QUEUE_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] port_id = '0, out_port = '0, ad_in = '0;
  logic       write_strobe = 1'b0;
  logic [7:0] donew_port, doner_port, datao_rtc_port, ad_out;
  logic       rtc_cs_n, rtc_wr_n, rtc_rd_n, rtc_ad, ad_oe;

  rtc_bus_driver #(.T_PHASE(T)) dut (
    .clock(clock), .reset(reset), .port_id(port_id), .out_port(out_port),
    .write_strobe(write_strobe), .donew_port(donew_port), .doner_port(doner_port),
    .datao_rtc_port(datao_rtc_port), .rtc_cs_n(rtc_cs_n), .rtc_wr_n(rtc_wr_n),
    .rtc_rd_n(rtc_rd_n), .rtc_ad(rtc_ad), .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit         rd;
    logic [7:0] addr;
    logic [7:0] data;
    int         start;
  } txn_t;

  txn_t exp_q[$];
  int   vectors = 0, miscompares = 0;
  int   edge_cnt = 0;
  int   busy_end = -1, pend_launch = -1;
  logic [7:0] m_addr = '0;

  // ad_in sampled at edge n carries ad_val(n), so read data is predictable.
  function automatic logic [7:0] ad_val(input int n);
    return 8'(n * 37 + 90) ^ 8'(n >> 3);
  endfunction

  always @(posedge clock) begin
    edge_cnt = edge_cnt + 1;
    #1 ad_in = ad_val(edge_cnt + 1);
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at edge %0d",
               name, act, act, exp, exp, edge_cnt);
    end
  endtask

  // Reference model: one cycle takes 7T+1 edges from the start edge until the
  // flag shows; an optional single slot launches one edge after the flag.
  function automatic void model(input int e, input logic [7:0] p, input logic [7:0] d);
    txn_t t;
    int   s;
    if (p == 8'h01) begin
      if (e > busy_end) m_addr = d;
      return;
    end
    if (p != 8'h02 && p != 8'h03) return;
    if (e > busy_end) s = e;
    else if (QEN && pend_launch < e) begin
      s = busy_end + 1;
      pend_launch = s;
    end else return;
    busy_end = s + TX;
    t.rd    = (p == 8'h03);
    t.addr  = m_addr;
    t.data  = t.rd ? ad_val(s + 6 * T) : d;
    t.start = s;
    exp_q.push_back(t);
  endfunction

  task automatic send(input logic [7:0] p, input logic [7:0] d);
    @(posedge clock); #2;
    port_id = p; out_port = d; write_strobe = 1'b1;
    model(edge_cnt + 1, p, d);
    @(posedge clock); #2;
    port_id = '0; out_port = '0; write_strobe = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("wait_done_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic idle_check(input int n);
    int bad = 0;
    repeat (n) begin
      @(negedge clock);
      if ({rtc_cs_n, rtc_wr_n, rtc_rd_n, ad_oe} != 4'b1110) bad++;
    end
    chk("idle_bus", bad, 0);
  endtask

  // Bus monitor
  int         aw = 0, dw = 0, rw = 0, oe_bad = 0, cs_fall = -1;
  logic [7:0] a_seen = '0, d_seen = '0;
  logic       prev_cs = 1'b1, prev_dw = 1'b0, prev_dr = 1'b0;

  task automatic check_txn(input bit is_wr);
    txn_t t;
    if (exp_q.size() == 0) begin
      chk("unexpected_done", 1, 0);
    end else begin
      t = exp_q.pop_front();
      chk("op_kind", int'(!is_wr), int'(t.rd));
      chk("start_edge", cs_fall, t.start);
      chk("done_edge", edge_cnt, t.start + TX);
      chk("addr_on_bus", int'(a_seen), int'(t.addr));
      chk("addr_strobe_len", aw, T);
      chk("oe_polarity", oe_bad, 0);
      if (t.rd) begin
        chk("read_data", int'(datao_rtc_port), int'(t.data));
        chk("rd_strobe_len", rw, T);
        chk("rd_no_data_wr", dw, 0);
        chk("donew_cleared", int'(donew_port[0]), 0);
      end else begin
        chk("write_data", int'(d_seen), int'(t.data));
        chk("wr_strobe_len", dw, T);
        chk("wr_no_rd", rw, 0);
        chk("doner_cleared", int'(doner_port[0]), 0);
      end
    end
    aw = 0; dw = 0; rw = 0; oe_bad = 0;
  endtask

  always @(negedge clock) begin
    if (reset) begin
      aw = 0; dw = 0; rw = 0; oe_bad = 0;
      prev_cs = 1'b1; prev_dw = 1'b0; prev_dr = 1'b0;
    end else begin
      if (!rtc_cs_n && prev_cs) cs_fall = edge_cnt;
      if (!rtc_wr_n && !rtc_ad) begin aw++; a_seen = ad_out; if (!ad_oe) oe_bad++; end
      if (!rtc_wr_n && rtc_ad)  begin dw++; d_seen = ad_out; if (!ad_oe) oe_bad++; end
      if (!rtc_rd_n) begin rw++; if (ad_oe || !rtc_ad) oe_bad++; end
      if (donew_port[0] && !prev_dw) check_txn(1'b1);
      if (doner_port[0] && !prev_dr) check_txn(1'b0);
      prev_cs = rtc_cs_n; prev_dw = donew_port[0]; prev_dr = doner_port[0];
    end
  end

  initial begin
    int s, n;
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;

    idle_check(20);
    chk("reset_donew", int'(donew_port), 0);
    chk("reset_doner", int'(doner_port), 0);
    chk("reset_datao", int'(datao_rtc_port), 0);
    chk("reset_ad_out", int'(ad_out), 0);

    send(8'h01, 8'h21);
    send(8'h02, 8'h45);
    @(negedge clock);
    chk("busy_during_write", int'(donew_port), 2);
    wait_done();
    chk("donew_after_write", int'(donew_port), 1);

    send(8'h01, 8'h22);
    send(8'h03, 8'h00);
    wait_done();
    chk("doner_after_read", int'(doner_port), 1);

    send(8'h02, 8'h11);
    repeat (30) @(posedge clock);
    send(8'h02, 8'h22);
    wait_done();
    chk("donew_after_overlap", int'(donew_port), 1);

    // Reset during D_STROBE of a write
    send(8'h01, 8'h05);
    send(8'h02, 8'hA5);
    s = exp_q[exp_q.size() - 1].start;
    n = 0;
    while (edge_cnt < s + 5 * T + 3 && n < 200) begin @(posedge clock); n++; end
    @(negedge clock);
    chk("pre_reset_wr_low", int'(rtc_wr_n), 0);
    reset = 1'b1;
    exp_q.delete();
    busy_end = -1; pend_launch = -1; m_addr = '0;
    @(negedge clock);
    chk("rst_cs_n", int'(rtc_cs_n), 1);
    chk("rst_wr_n", int'(rtc_wr_n), 1);
    chk("rst_donew", int'(donew_port), 0);
    chk("rst_doner", int'(doner_port), 0);
    @(posedge clock); #2 reset = 1'b0;

    send(8'h07, 8'hFF);
    idle_check(20);
    send(8'h03, 8'h00);
    wait_done();

    for (int i = 0; i < 60; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 3)      send(8'h01, 8'($urandom));
      else if (r < 6) send(8'h02, 8'($urandom));
      else if (r < 9) send(8'h03, 8'($urandom));
      else            send(8'($urandom_range(4, 255)), 8'($urandom));
      repeat ($urandom_range(0, 3 * T)) @(posedge clock);
    end
    wait_done();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
